// File: rtl/cnn_data_loader_pkg.sv
// Shared constants and encodings for the conv-engine RAM loader.
// Default element format is fp16; FILL_VALUE defaults to fp16 1.0.
package cnn_data_loader_pkg;

  localparam int unsigned         DEF_DATA_WIDTH = 16;
  localparam logic [15:0]         DEF_FILL_VALUE = 16'h3c00;

  localparam logic DEST_FM = 1'b0;
  localparam logic DEST_WT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_FILL,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/cnn_data_loader_packer.sv
// Collects stream elements into one RAM line, lane 0 in the LSBs.
// line_full/line_data are combinational on the completing beat so the caller can register the write.
module cnn_line_packer
  import cnn_data_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LANES  = 16,
  localparam int IDX_W     = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1,
  localparam int LANE_W    = $clog2(MAX_LANES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            beat,
  input  logic [DATA_WIDTH-1:0]           data,
  input  logic [LANE_W-1:0]               lanes,
  output logic                            line_full,
  output logic [MAX_LANES*DATA_WIDTH-1:0] line_data
);

  logic [IDX_W-1:0]                       elem_idx_q, elem_idx_d;
  logic [MAX_LANES-1:0][DATA_WIDTH-1:0]   line_q, line_d;

  // clear also suppresses a completing beat, so an aborted line is never reported
  always_comb begin
    elem_idx_d = elem_idx_q;
    line_d     = line_q;
    line_full  = 1'b0;
    if (beat) begin
      line_d[elem_idx_q] = data;
      if (LANE_W'(elem_idx_q) == lanes - LANE_W'(1)) begin
        line_full  = 1'b1;
        elem_idx_d = '0;
      end else begin
        elem_idx_d = elem_idx_q + IDX_W'(1);
      end
    end
    if (clear) begin
      elem_idx_d = '0;
      line_full  = 1'b0;
    end
  end

  assign line_data = line_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_idx_q <= '0;
      line_q     <= '0;
    end else begin
      elem_idx_q <= elem_idx_d;
      line_q     <= line_d;
    end
  end

endmodule

// File: rtl/cnn_data_loader.sv
// Loads fm / weight RAM lines from a stream or a constant fill, one command at a time.
// Writes are registered; done follows the final write by one cycle.
module cnn_data_loader
  import cnn_data_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    FM_LANES   = 8,
  parameter int                    WT_LANES   = 16,
  parameter int                    FM_ADDR_W  = 10,
  parameter int                    WT_ADDR_W  = 10,
  parameter int                    CNT_W      = 12,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DEF_FILL_VALUE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_dest,
  input  logic                           cmd_bank,
  input  logic                           cmd_fill,
  input  logic [WT_ADDR_W-1:0]           cmd_base,
  input  logic [CNT_W-1:0]               cmd_lines,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           abort,
  output logic                           fm_wr_en,
  output logic [FM_ADDR_W-1:0]           fm_wr_addr,
  output logic [FM_LANES*DATA_WIDTH-1:0] fm_wr_data,
  output logic                           wt_wr_en,
  output logic [WT_ADDR_W-1:0]           wt_wr_addr,
  output logic [WT_LANES*DATA_WIDTH-1:0] wt_wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted
);

  localparam int MAX_LANES = (FM_LANES > WT_LANES) ? FM_LANES : WT_LANES;
  localparam int LANE_W    = $clog2(MAX_LANES + 1);

  state_e                         state_q, state_d;
  logic                           dest_q, dest_d;
  logic                           bank_q, bank_d;
  logic [WT_ADDR_W-1:0]           base_q, base_d;
  logic [CNT_W-1:0]               lines_q, lines_d;
  logic [CNT_W-1:0]               line_idx_q, line_idx_d;
  logic                           aborted_q, aborted_d;
  logic                           fm_wr_en_q, fm_wr_en_d;
  logic [FM_ADDR_W-1:0]           fm_wr_addr_q, fm_wr_addr_d;
  logic [FM_LANES*DATA_WIDTH-1:0] fm_wr_data_q, fm_wr_data_d;
  logic                           wt_wr_en_q, wt_wr_en_d;
  logic [WT_ADDR_W-1:0]           wt_wr_addr_q, wt_wr_addr_d;
  logic [WT_LANES*DATA_WIDTH-1:0] wt_wr_data_q, wt_wr_data_d;

  logic                            all_written;
  logic                            do_write;
  logic                            fill_line;
  logic                            pk_clear;
  logic                            pk_beat;
  logic                            pk_line_full;
  logic [LANE_W-1:0]               pk_lanes;
  logic [MAX_LANES*DATA_WIDTH-1:0] pk_line_data;
  logic [FM_ADDR_W-1:0]            fm_addr;
  logic [WT_ADDR_W-2:0]            wt_offset;

  assign all_written = (line_idx_q == lines_q);
  assign s_ready     = (state_q == ST_PACK) && !all_written;
  assign pk_beat     = s_valid && s_ready;
  assign pk_lanes    = (dest_q == DEST_WT) ? LANE_W'(WT_LANES) : LANE_W'(FM_LANES);

  // weight offset is computed one bit narrower so it wraps inside the selected bank half
  assign fm_addr   = FM_ADDR_W'(base_q) + FM_ADDR_W'(line_idx_q);
  assign wt_offset = (WT_ADDR_W-1)'(base_q) + (WT_ADDR_W-1)'(line_idx_q);

  cnn_line_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_LANES  (MAX_LANES)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .beat      (pk_beat),
    .data      (s_data),
    .lanes     (pk_lanes),
    .line_full (pk_line_full),
    .line_data (pk_line_data)
  );

  // the final write is still on the outputs when all_written is seen, so FINISH lands one cycle later
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    bank_d       = bank_q;
    base_d       = base_q;
    lines_d      = lines_q;
    line_idx_d   = line_idx_q;
    aborted_d    = aborted_q;
    fm_wr_en_d   = 1'b0;
    fm_wr_addr_d = fm_wr_addr_q;
    fm_wr_data_d = fm_wr_data_q;
    wt_wr_en_d   = 1'b0;
    wt_wr_addr_d = wt_wr_addr_q;
    wt_wr_data_d = wt_wr_data_q;
    do_write     = 1'b0;
    fill_line    = 1'b0;
    pk_clear     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dest_d     = cmd_dest;
          bank_d     = cmd_bank;
          base_d     = cmd_base;
          lines_d    = cmd_lines;
          line_idx_d = '0;
          aborted_d  = 1'b0;
          if (cmd_lines == '0) begin
            state_d = ST_FINISH;
          end else if (cmd_fill) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_PACK;
          end
        end
      end
      ST_PACK: begin
        pk_clear = abort;
        if (abort) begin
          state_d   = ST_FINISH;
          aborted_d = 1'b1;
        end else if (all_written) begin
          state_d = ST_FINISH;
        end else if (pk_line_full) begin
          do_write = 1'b1;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d   = ST_FINISH;
          aborted_d = 1'b1;
        end else if (all_written) begin
          state_d = ST_FINISH;
        end else begin
          do_write  = 1'b1;
          fill_line = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_write) begin
      line_idx_d = line_idx_q + CNT_W'(1);
      if (dest_q == DEST_WT) begin
        wt_wr_en_d   = 1'b1;
        wt_wr_addr_d = {bank_q, wt_offset};
        wt_wr_data_d = fill_line ? {WT_LANES{FILL_VALUE}}
                                 : pk_line_data[WT_LANES*DATA_WIDTH-1:0];
      end else begin
        fm_wr_en_d   = 1'b1;
        fm_wr_addr_d = fm_addr;
        fm_wr_data_d = fill_line ? {FM_LANES{FILL_VALUE}}
                                 : pk_line_data[FM_LANES*DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dest_q       <= 1'b0;
      bank_q       <= 1'b0;
      base_q       <= '0;
      lines_q      <= '0;
      line_idx_q   <= '0;
      aborted_q    <= 1'b0;
      fm_wr_en_q   <= 1'b0;
      fm_wr_addr_q <= '0;
      fm_wr_data_q <= '0;
      wt_wr_en_q   <= 1'b0;
      wt_wr_addr_q <= '0;
      wt_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      bank_q       <= bank_d;
      base_q       <= base_d;
      lines_q      <= lines_d;
      line_idx_q   <= line_idx_d;
      aborted_q    <= aborted_d;
      fm_wr_en_q   <= fm_wr_en_d;
      fm_wr_addr_q <= fm_wr_addr_d;
      fm_wr_data_q <= fm_wr_data_d;
      wt_wr_en_q   <= wt_wr_en_d;
      wt_wr_addr_q <= wt_wr_addr_d;
      wt_wr_data_q <= wt_wr_data_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign aborted    = (state_q == ST_FINISH) && aborted_q;
  assign fm_wr_en   = fm_wr_en_q;
  assign fm_wr_addr = fm_wr_addr_q;
  assign fm_wr_data = fm_wr_data_q;
  assign wt_wr_en   = wt_wr_en_q;
  assign wt_wr_addr = wt_wr_addr_q;
  assign wt_wr_data = wt_wr_data_q;

endmodule

// File: tb/tb_cnn_data_loader.sv
// Scoreboard bench for cnn_data_loader: expected RAM writes are queued as stimulus is
// driven and popped by a negedge monitor whenever either write strobe is seen.
module tb_cnn_data_loader;

  localparam int DW  = 16;
  localparam int FML = 8;
  localparam int WTL = 16;
  localparam int AW  = 10;
  localparam int CW  = 12;
  localparam logic [DW-1:0] FILL = 16'h3c00;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_dest, cmd_bank, cmd_fill;
  logic [AW-1:0]     cmd_base;
  logic [CW-1:0]     cmd_lines;
  logic [DW-1:0]     s_data;
  logic              s_valid, s_ready, abort;
  logic              fm_wr_en, wt_wr_en;
  logic [AW-1:0]     fm_wr_addr, wt_wr_addr;
  logic [FML*DW-1:0] fm_wr_data;
  logic [WTL*DW-1:0] wt_wr_data;
  logic              busy, done, aborted;

  always #5 clk = ~clk;

  cnn_data_loader dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dest   (cmd_dest),
    .cmd_bank   (cmd_bank),
    .cmd_fill   (cmd_fill),
    .cmd_base   (cmd_base),
    .cmd_lines  (cmd_lines),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .abort      (abort),
    .fm_wr_en   (fm_wr_en),
    .fm_wr_addr (fm_wr_addr),
    .fm_wr_data (fm_wr_data),
    .wt_wr_en   (wt_wr_en),
    .wt_wr_addr (wt_wr_addr),
    .wt_wr_data (wt_wr_data),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  typedef struct {
    logic              dest;
    logic [AW-1:0]     addr;
    logic [WTL*DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   last_wr_cyc = -1;
  int   wr_seen     = 0;
  int   done_cyc    = -1;
  bit   timed_out   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (fm_wr_en === 1'b1 || wt_wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write fm_wr_en=%0b wt_wr_en=%0b fm_addr=%h wt_addr=%h required=no write",
                 fm_wr_en, wt_wr_en, fm_wr_addr, wt_wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.dest == 1'b0) begin
          if (fm_wr_en !== 1'b1 || wt_wr_en !== 1'b0 || fm_wr_addr !== e.addr ||
              fm_wr_data !== e.data[FML*DW-1:0]) begin
            failures++;
            $display("[TB] FAIL fm_write en=%0b/%0b addr=%h data=%h required en=1/0 addr=%h data=%h",
                     fm_wr_en, wt_wr_en, fm_wr_addr, fm_wr_data, e.addr, e.data[FML*DW-1:0]);
          end
        end else begin
          if (wt_wr_en !== 1'b1 || fm_wr_en !== 1'b0 || wt_wr_addr !== e.addr ||
              wt_wr_data !== e.data) begin
            failures++;
            $display("[TB] FAIL wt_write en=%0b/%0b addr=%h data=%h required en=0/1 addr=%h data=%h",
                     fm_wr_en, wt_wr_en, wt_wr_addr, wt_wr_data, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_stream_line(input logic dest, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] first, input int n);
    exp_t e;
    e.dest = dest;
    e.addr = addr;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i*DW +: DW] = first + DW'(i);
    exp_q.push_back(e);
  endtask

  task automatic push_fill_line(input logic dest, input logic [AW-1:0] addr, input int n);
    exp_t e;
    e.dest = dest;
    e.addr = addr;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i*DW +: DW] = FILL;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic dest, input logic bank, input logic fill,
                          input logic [AW-1:0] base, input logic [CW-1:0] lines);
    cmd_valid = 1'b1;
    cmd_dest  = dest;
    cmd_bank  = bank;
    cmd_fill  = fill;
    cmd_base  = base;
    cmd_lines = lines;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [DW-1:0] v, input bit gap);
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = v;
    for (int i = 0; i < 50 && s_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    if (s_ready !== 1'b1) timed_out = 1'b1;
    else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_dest = 1'b0; cmd_bank = 1'b0; cmd_fill = 1'b0;
    cmd_base = '0; cmd_lines = '0; s_data = '0; s_valid = 1'b0; abort = 1'b0;
    #13;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_status ready=%0b busy=%0b done=%0b aborted=%0b s_ready=%0b required 1 0 0 0 0",
               cmd_ready, busy, done, aborted, s_ready);
    end
    checks++;
    if (fm_wr_en !== 1'b0 || wt_wr_en !== 1'b0 || fm_wr_addr !== '0 || wt_wr_addr !== '0 ||
        fm_wr_data !== '0 || wt_wr_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_write_ports fm_en=%0b wt_en=%0b fm_addr=%h wt_addr=%h required all zero",
               fm_wr_en, wt_wr_en, fm_wr_addr, wt_wr_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fm_stream();
    int wr0 = wr_seen;
    timed_out = 1'b0;
    for (int l = 0; l < 3; l++) push_stream_line(1'b0, AW'(5 + l), DW'(1 + 8*l), FML);
    send_cmd(1'b0, 1'b0, 1'b0, 10'd5, 12'd3);
    for (int v = 1; v <= 24; v++) send_elem(DW'(v), 1'b0);
    wait_done(20);
    checks++;
    if (timed_out !== 1'b0 || wr_seen - wr0 != 3 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL fm_stream_count writes=%0d pending=%0d stall=%0b required 3 0 0",
               wr_seen - wr0, exp_q.size(), timed_out);
    end
    checks++;
    if (done_cyc != last_wr_cyc + 1 || aborted !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fm_stream_done done_cyc=%0d aborted=%0b required %0d 0",
               done_cyc, aborted, last_wr_cyc + 1);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fm_stream_idle ready=%0b done=%0b required 1 0", cmd_ready, done);
    end
  endtask

  task automatic test_wt_fill();
    int wr0 = wr_seen;
    int first_wr = -1;
    int last_wr = -1;
    int n_wr = 0;
    int sready_hi = 0;
    push_fill_line(1'b1, 10'h3FE, WTL);
    push_fill_line(1'b1, 10'h3FF, WTL);
    push_fill_line(1'b1, 10'h200, WTL);
    push_fill_line(1'b1, 10'h201, WTL);
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    send_cmd(1'b1, 1'b1, 1'b1, 10'd510, 12'd4);
    done_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (s_ready !== 1'b0) sready_hi++;
      if (wt_wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++;
    if (n_wr != 4 || last_wr - first_wr != 3 || wr_seen - wr0 != 4 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL wt_fill_burst writes=%0d span=%0d pending=%0d required 4 3 0",
               n_wr, last_wr - first_wr, exp_q.size());
    end
    checks++;
    if (sready_hi != 0) begin
      failures++;
      $display("[TB] FAIL wt_fill_s_ready cycles_high=%0d required 0", sready_hi);
    end
    checks++;
    if (done_cyc != last_wr + 1) begin
      failures++;
      $display("[TB] FAIL wt_fill_done done_cyc=%0d required %0d", done_cyc, last_wr + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped_stream();
    int wr0 = wr_seen;
    timed_out = 1'b0;
    for (int l = 0; l < 2; l++) push_stream_line(1'b0, AW'(5 + l), DW'(1 + 8*l), FML);
    send_cmd(1'b0, 1'b0, 1'b0, 10'd5, 12'd2);
    for (int v = 1; v <= 16; v++) send_elem(DW'(v), 1'b1);
    wait_done(20);
    checks++;
    if (timed_out !== 1'b0 || wr_seen - wr0 != 2 || exp_q.size() != 0 || done_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("[TB] FAIL gapped_stream writes=%0d pending=%0d done_cyc=%0d required 2 0 %0d",
               wr_seen - wr0, exp_q.size(), done_cyc, last_wr_cyc + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_lines();
    int wr0 = wr_seen;
    send_cmd(1'b0, 1'b0, 1'b0, 10'd7, 12'd0);
    checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_lines_done done=%0b aborted=%0b ready=%0b required 1 0 0",
               done, aborted, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || wr_seen != wr0) begin
      failures++;
      $display("[TB] FAIL zero_lines_idle done=%0b ready=%0b writes=%0d required 0 1 0",
               done, cmd_ready, wr_seen - wr0);
    end
  endtask

  task automatic test_abort();
    int wr0 = wr_seen;
    timed_out = 1'b0;
    push_stream_line(1'b1, 10'd3, 16'h0101, WTL);
    send_cmd(1'b1, 1'b0, 1'b0, 10'd3, 12'd3);
    for (int v = 0; v < WTL; v++) send_elem(DW'(16'h0101 + v), 1'b0);
    for (int v = 0; v < 5; v++) send_elem(DW'(16'h0201 + v), 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_pulse done=%0b aborted=%0b required 1 1", done, aborted);
    end
    checks++;
    if (timed_out !== 1'b0 || wr_seen - wr0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL abort_writes writes=%0d pending=%0d required 1 0", wr_seen - wr0, exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_idle done=%0b aborted=%0b ready=%0b required 0 0 1", done, aborted, cmd_ready);
    end
    wr0 = wr_seen;
    push_stream_line(1'b0, 10'd20, 16'h0301, FML);
    send_cmd(1'b0, 1'b0, 1'b0, 10'd20, 12'd1);
    for (int v = 0; v < FML; v++) send_elem(DW'(16'h0301 + v), 1'b0);
    wait_done(20);
    checks++;
    if (timed_out !== 1'b0 || wr_seen - wr0 != 1 || exp_q.size() != 0 || done_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("[TB] FAIL abort_followup writes=%0d pending=%0d done_cyc=%0d required 1 0 %0d",
               wr_seen - wr0, exp_q.size(), done_cyc, last_wr_cyc + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort_last_beat();
    int wr0 = wr_seen;
    timed_out = 1'b0;
    send_cmd(1'b0, 1'b0, 1'b0, 10'd0, 12'd1);
    for (int v = 1; v < FML; v++) send_elem(DW'(v), 1'b0);
    s_valid = 1'b1;
    s_data  = DW'(FML);
    abort   = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    abort   = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_last_pulse done=%0b aborted=%0b required 1 1", done, aborted);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (timed_out !== 1'b0 || wr_seen != wr0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_last_nowrite writes=%0d ready=%0b required 0 1", wr_seen - wr0, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_fill();
    int wr0 = wr_seen;
    int done_seen = 0;
    timed_out = 1'b0;
    for (int l = 0; l < 10; l++) push_fill_line(1'b0, AW'(l), FML);
    send_cmd(1'b0, 1'b0, 1'b1, 10'd0, 12'd10);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (fm_wr_en !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 ||
        fm_wr_addr !== '0 || fm_wr_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_clear en=%0b busy=%0b ready=%0b done=%0b addr=%h required 0 0 1 0 0",
               fm_wr_en, busy, cmd_ready, done, fm_wr_addr);
    end
    checks++;
    if (wr_seen - wr0 != 1 || exp_q.size() != 9) begin
      failures++;
      $display("[TB] FAIL reset_mid_partial writes=%0d pending=%0d required 1 9", wr_seen - wr0, exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_done cycles_done=%0d required 0", done_seen);
    end
    wr0 = wr_seen;
    push_stream_line(1'b0, 10'd40, 16'h0401, FML);
    send_cmd(1'b0, 1'b0, 1'b0, 10'd40, 12'd1);
    for (int v = 0; v < FML; v++) send_elem(DW'(16'h0401 + v), 1'b0);
    wait_done(20);
    checks++;
    if (timed_out !== 1'b0 || wr_seen - wr0 != 1 || exp_q.size() != 0 || done_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("[TB] FAIL reset_mid_recover writes=%0d pending=%0d done_cyc=%0d required 1 0 %0d",
               wr_seen - wr0, exp_q.size(), done_cyc, last_wr_cyc + 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fm_stream();
    test_wt_fill();
    test_gapped_stream();
    test_zero_lines();
    test_abort();
    test_abort_last_beat();
    test_reset_mid_fill();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
